// File: rtl/sr_flag_bank.sv
// Bank of CH clocked set/reset flags with configurable conflict resolution,
// optional edge-triggered inputs, rise/conflict pulses and a saturating conflict counter.

module sr_flag_lane #(
  parameter int MODE = 0,
  parameter int EDGE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  input  logic clr_all,
  output logic q,
  output logic rise,
  output logic conflict,
  output logic conf_now
);
  logic eff_s, eff_r, q_next;

  if (EDGE != 0) begin : g_edge
    logic s_d, r_d;
    // History is cleared by reset, so a level already high after reset counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_d <= 1'b0;
        r_d <= 1'b0;
      end else begin
        s_d <= s;
        r_d <= r;
      end
    end
    assign eff_s = s & ~s_d;
    assign eff_r = r & ~r_d;
  end else begin : g_level
    assign eff_s = s;
    assign eff_r = r;
  end

  assign conf_now = eff_s & eff_r;

  always_comb begin
    q_next = q;
    if (clr_all) begin
      q_next = 1'b0;
    end else begin
      case ({eff_s, eff_r})
        2'b10:   q_next = 1'b1;
        2'b01:   q_next = 1'b0;
        2'b11: begin
          case (MODE)
            0:       q_next = 1'b0;
            1:       q_next = 1'b1;
            2:       q_next = ~q;
            default: q_next = q;
          endcase
        end
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= 1'b0;
      rise     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      q        <= q_next;
      rise     <= q_next & ~q;
      conflict <= conf_now;
    end
  end
endmodule

module sr_flag_bank #(
  parameter int CH    = 8,
  parameter int MODE  = 0,
  parameter int EDGE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    s,
  input  logic [CH-1:0]    r,
  input  logic             clr_all,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    q_b,
  output logic [CH-1:0]    rise,
  output logic [CH-1:0]    conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             any_q
);
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $fatal(1, "sr_flag_bank: MODE must be 0..3");
  end
  if (EDGE < 0 || EDGE > 1) begin : g_bad_edge
    $fatal(1, "sr_flag_bank: EDGE must be 0 or 1");
  end
  if (CH < 1 || CNT_W < 1) begin : g_bad_size
    $fatal(1, "sr_flag_bank: CH and CNT_W must be >= 1");
  end

  logic [CH-1:0] conf_now;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    sr_flag_lane #(.MODE(MODE), .EDGE(EDGE)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .s        (s[i]),
      .r        (r[i]),
      .clr_all  (clr_all),
      .q        (q[i]),
      .rise     (rise[i]),
      .conflict (conflict[i]),
      .conf_now (conf_now[i])
    );
  end

  assign q_b   = ~q;
  assign any_q = |q;

  // One count per cycle regardless of how many channels collide; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (clr_all) begin
      conflict_cnt <= '0;
    end else if ((|conf_now) && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule
